otter_mem_arbiter: RTL and testbench
====================================

# otter_mem_arbiter

Sequences all memory and I/O traffic of the multicycle OTTER_MCU. It shares one single-ported memory between the instruction-fetch port and the load/store port. Data-port accesses in the I/O region are routed to the IOBUS instead of the memory. The block sits between the CPU control FSM and the 1-cycle-latency memory/IOBUS, and owns all access timing.

## Interface
Parameters:
- `ADDR_W`, default 32, address width of all ports.
- `DATA_W`, default 32, data width; byte enables are `DATA_W/8` bits wide.
- `IO_TAG`, default 8'h11, value of `addr[31:24]` that selects the IOBUS (data port only).

Ports. One clock; reset is asynchronous and active-high.
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high, with `if_addr` stable, until `if_valid`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; meaningful only while `if_valid`=1.
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held high, with all `d_*` inputs stable, until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_be`  in  DATA_W/8  store byte enables.
- `d_rdata`  out  DATA_W  load data; meaningful only while `d_valid`=1.
- `d_valid`  out  1  one-cycle load/store completion pulse.
- `mem_en`, `mem_we`  out  1  memory access strobe and write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data; valid one cycle after `mem_en`.
- `IOBUS_ADDR`, `IOBUS_OUT`  out  32  I/O address and I/O write data.
- `IOBUS_WR`  out  1  I/O write strobe.
- `IOBUS_IN`  in  32  I/O read data; combinational from `IOBUS_ADDR`.

## Operation
- The FSM has three states: `IDLE`, `RESP_IF`, `RESP_D`.
- `IDLE`, no request: all strobes stay low.
- `IDLE`, only `if_req`: grant fetch.
- `IDLE`, only `d_req`: grant data.
- `IDLE`, both requests: grant the port that did not win last. The `last_grant` register resets to IF, so the first tie goes to data.
- On a grant, in the same cycle:
  - Fetch grant: `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr`. Next state `RESP_IF`.
  - Data grant to memory (`d_addr[31:24]`≠`IO_TAG`): `mem_en`=1, `mem_we`=`d_we`, plus addr/wdata/be. Next state `RESP_D`.
  - Data grant to I/O (`d_addr[31:24]`=`IO_TAG`): `mem_en`=0, `IOBUS_ADDR`=`d_addr`, `IOBUS_OUT`=`d_wdata`, `IOBUS_WR`=`d_we`. On load, `IOBUS_IN` is latched into `io_rdata` at this clock edge. Next state `RESP_D`.
- `RESP_IF`: `if_valid`=1 and `if_rdata`=`mem_rdata`. Next state is always `IDLE`. No access is issued in a RESP state.
- `RESP_D`: `d_valid`=1. `d_rdata`=`io_rdata` if the access was I/O, else `mem_rdata`. Next state is `IDLE`. Stores also pulse `d_valid`, acting as the acknowledge.
- A store with `d_be`=0 still issues `mem_we`=1 and completes normally.
- `d_be` does not apply to the IOBUS; I/O writes are full-word.
- Fetches to `IO_TAG` addresses go to memory; there is no I/O routing on the fetch port.

## Timing
- Every access takes exactly 2 cycles: grant cycle, then response cycle. Maximum throughput is one access per 2 cycles.
- A request high in cycle N while in `IDLE` gets its valid pulse in cycle N+1.
- A loser under contention is granted in the next `IDLE`, at cycle N+2. Neither port waits more than one foreign access.
- `mem_*` and `IOBUS_*` outputs are combinational from state and request. The `valid` outputs decode the registered state.
- Reset values:
  - state=`IDLE`, `last_grant`=IF, `io_rdata`=0.
  - `if_valid`=`d_valid`=0, `mem_en`=`mem_we`=`IOBUS_WR`=0.
  - Address, data and byte-enable outputs are 0.
- `RESET` asserted mid-access aborts the access immediately: no valid pulse is produced and any strobe drops asynchronously. The requester reissues.
- A request dropped before its valid pulse is a protocol violation. The response is still produced.

## Structure
- Package `otter_mem_pkg` holds:
  - `arb_state_t` enum (`IDLE`, `RESP_IF`, `RESP_D`).
  - `port_t` enum (`PORT_IF`, `PORT_D`).
  - `IO_TAG_DEFAULT`.
- The block is a single module with no sub-module. The FSM, arbitration and routing mux are one unit.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x100, memory word 0x00500093 → `mem_en` in cycle 0, `if_valid` with `if_rdata`=0x00500093 in cycle 1.
- Simultaneous requests after reset: fetch 0x104 and load 0x2000 → data granted first (`d_valid` in cycle 1), fetch `if_valid` in cycle 3. Repeat the tie → fetch is granted first.
- Store: `d_addr`=0x2004, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011 → `mem_we`=1 and `mem_be`=0011 in the grant cycle, `d_valid` next cycle. A following load returns 0x0000BEEF over a zero-initialized word.
- I/O: store to 0x11000020 with data 0xA5 → `IOBUS_WR`=1, `IOBUS_ADDR`=0x11000020, `IOBUS_OUT`=0xA5, `mem_en`=0. Load from 0x11000000 with `IOBUS_IN`=0x1234 → `d_rdata`=0x1234 on `d_valid`.
- Back-to-back fetches held high for 4 requests → `if_valid` in cycles 1, 3, 5, 7 and never on consecutive cycles.
- `RESET` pulsed in the `RESP_D` cycle → `d_valid` stays 0, state returns to `IDLE`, and a reissued load completes 2 cycles after reset release.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types for the OTTER memory arbiter
package otter_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  localparam logic [7:0] IO_TAG_DEFAULT = 8'h11;

endpackage

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - fetch/load-store arbiter for one single-ported memory plus IOBUS
module otter_mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [7:0] IO_TAG = otter_mem_pkg::IO_TAG_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [31:0]         IOBUS_ADDR,
  output logic [31:0]         IOBUS_OUT,
  output logic                IOBUS_WR,
  input  logic [31:0]         IOBUS_IN
);
  import otter_mem_pkg::*;

  arb_state_t  state_q, state_d;
  port_t       last_grant_q, last_grant_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic        d_io_q, d_io_d;
  logic        grant_if, grant_d, d_is_io;

  assign d_is_io = (d_addr[31:24] == IO_TAG);

  // Grants are gated by RESET so strobes drop the moment reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE && !RESET) begin
      if (if_req && d_req) begin
        if (last_grant_q == PORT_IF) grant_d = 1'b1;
        else                         grant_if = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_IF;
      io_rdata_q   <= '0;
      d_io_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      io_rdata_q   <= io_rdata_d;
      d_io_q       <= d_io_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    io_rdata_d   = io_rdata_q;
    d_io_d       = d_io_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d      = RESP_IF;
          last_grant_d = PORT_IF;
        end else if (grant_d) begin
          state_d      = RESP_D;
          last_grant_d = PORT_D;
          d_io_d       = d_is_io;
          // IOBUS_IN is combinational, so capture it while the address is still driven.
          if (d_is_io && !d_we) io_rdata_d = IOBUS_IN;
        end
      end
      RESP_IF: state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (grant_d && !d_is_io) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (grant_d) begin
      IOBUS_ADDR = d_addr[31:0];
      IOBUS_OUT  = d_wdata[31:0];
      IOBUS_WR   = d_we;
    end
  end

  assign if_valid = (state_q == RESP_IF);
  assign d_valid  = (state_q == RESP_D);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign d_rdata  = !d_valid ? '0 : (d_io_q ? DATA_W'(io_rdata_q) : mem_rdata);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - self-checking bench for otter_mem_arbiter
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        RESET;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, d_valid, mem_en, mem_we, IOBUS_WR;
  logic [3:0]  mem_be;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, io_in;

  int n_vec = 0;
  int n_err = 0;

  otter_mem_arbiter dut (
    .CLK(clk), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .IOBUS_IN(io_in)
  );

  always #5 clk = ~clk;

  // Environment: 1-cycle-latency synchronous RAM, read-before-write.
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[13:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected memory contents plus the pending response of the current access.
  logic [31:0] mmod [int];
  int          pend = 0;
  logic [31:0] resp;
  bit          resp_chk, last_d;

  function automatic logic [31:0] mread(input logic [31:0] a);
    int k = int'(a[13:2]);
    return mmod.exists(k) ? mmod[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    int   win;
    bit   is_io;
    logic [31:0] w;
    if (RESET) begin
      chk("reset if_valid", if_valid, 0);
      chk("reset d_valid", d_valid, 0);
      chk("reset mem_en", mem_en, 0);
      chk("reset mem_we", mem_we, 0);
      chk("reset iobus_wr", IOBUS_WR, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_be", mem_be, 0);
      chk("reset iobus_addr", IOBUS_ADDR, 0);
      pend   = 0;
      last_d = 1'b0;
    end else if (pend != 0) begin
      chk("resp if_valid", if_valid, pend == 1);
      chk("resp d_valid", d_valid, pend == 2);
      chk("resp mem_en", mem_en, 0);
      chk("resp iobus_wr", IOBUS_WR, 0);
      if (pend == 1) chk("model if_rdata", if_rdata, resp);
      else if (resp_chk) chk("model d_rdata", d_rdata, resp);
      pend = 0;
    end else begin
      if (if_req && d_req) win = last_d ? 1 : 2;
      else if (if_req)     win = 1;
      else if (d_req)      win = 2;
      else                 win = 0;
      is_io = (d_addr[31:24] == 8'h11);
      chk("idle if_valid", if_valid, 0);
      chk("idle d_valid", d_valid, 0);
      chk("grant mem_en", mem_en, win == 1 || (win == 2 && !is_io));
      chk("grant mem_we", mem_we, win == 2 && !is_io && d_we);
      chk("grant iobus_wr", IOBUS_WR, win == 2 && is_io && d_we);
      if (win == 1) begin
        chk("fetch mem_addr", mem_addr, if_addr);
        resp = mread(if_addr);
        resp_chk = 1'b1;
        last_d = 1'b0;
        pend = 1;
      end else if (win == 2) begin
        resp_chk = !d_we;
        last_d = 1'b1;
        pend = 2;
        if (is_io) begin
          chk("io addr", IOBUS_ADDR, d_addr);
          chk("io out", IOBUS_OUT, d_wdata);
          resp = io_in;
        end else begin
          chk("data mem_addr", mem_addr, d_addr);
          chk("data mem_wdata", mem_wdata, d_wdata);
          chk("data mem_be", mem_be, d_be);
          resp = mread(d_addr);
          if (d_we) begin
            w = resp;
            for (int b = 0; b < 4; b++) if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
            mmod[int'(d_addr[13:2])] = w;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ram[a[13:2]] = v;
    mmod[int'(a[13:2])] = v;
  endtask

  logic [31:0] fetch_addrs [4];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    preload(32'h100, 32'h00500093);
    preload(32'h104, 32'h00A00113);
    preload(32'h108, 32'h002081B3);
    preload(32'h11000040, 32'hCAFEF00D);
    fetch_addrs[0] = 32'h100; fetch_addrs[1] = 32'h104;
    fetch_addrs[2] = 32'h108; fetch_addrs[3] = 32'h11000040;
    RESET = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; io_in = 0;
    step(); step();
    RESET = 1'b0;

    // Tie right after reset: data wins, then fetch wins the next tie.
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
    at_neg(); chk("tie0 data first", mem_addr, 32'h2000);
    step(); at_neg(); chk("tie0 d_valid", d_valid, 1);
    step(); at_neg(); chk("tie1 fetch first", mem_addr, 32'h104);
    step(); at_neg(); chk("tie1 if_valid", if_valid, 1); chk("tie1 if_rdata", if_rdata, 32'h00A00113);
    step(); if_req = 0;
    at_neg(); chk("tie loser load granted", mem_addr, 32'h2000);
    step(); at_neg(); chk("tie loser d_valid", d_valid, 1);
    step(); d_req = 0;

    // Fetch only.
    if_req = 1; if_addr = 32'h100;
    at_neg(); chk("fetch mem_en c0", mem_en, 1);
    step(); at_neg(); chk("fetch if_valid c1", if_valid, 1); chk("fetch if_rdata c1", if_rdata, 32'h00500093);
    step(); if_req = 0;
    at_neg(); chk("idle no strobe", mem_en, 0);
    step();

    // Partial store then readback.
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    at_neg(); chk("store mem_we", mem_we, 1); chk("store mem_be", mem_be, 4'b0011);
    step(); at_neg(); chk("store d_valid", d_valid, 1);
    step(); d_we = 0; d_be = 0;
    at_neg(); chk("load mem_we", mem_we, 0);
    step(); at_neg(); chk("load d_rdata", d_rdata, 32'h0000BEEF);
    step();

    // Store with no byte enables still strobes and leaves the word untouched.
    d_we = 1; d_addr = 32'h2008; d_wdata = 32'hFFFFFFFF; d_be = 4'b0000;
    at_neg(); chk("be0 mem_we", mem_we, 1);
    step(); at_neg(); chk("be0 d_valid", d_valid, 1);
    step(); d_we = 0;
    step(); at_neg(); chk("be0 readback", d_rdata, 32'h0);
    step();

    // I/O store and load; IOBUS_IN changes after the grant edge.
    d_we = 1; d_addr = 32'h11000020; d_wdata = 32'hA5; d_be = 4'b0001;
    at_neg();
    chk("io wr", IOBUS_WR, 1); chk("io addr lit", IOBUS_ADDR, 32'h11000020);
    chk("io out lit", IOBUS_OUT, 32'hA5); chk("io mem_en", mem_en, 0);
    step(); at_neg(); chk("io store d_valid", d_valid, 1);
    step(); d_we = 0; d_addr = 32'h11000000; io_in = 32'h1234;
    at_neg(); chk("io load mem_en", mem_en, 0);
    step(); io_in = 32'hFFFF;
    at_neg(); chk("io load d_valid", d_valid, 1); chk("io load d_rdata", d_rdata, 32'h1234);
    step(); d_req = 0;

    // Back-to-back fetches, the last one to an IO-tag address that must still hit memory.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) if_addr = fetch_addrs[k/2];
      if_req = 1;
      at_neg(); chk("b2b if_valid", if_valid, k % 2);
      if (k == 6) chk("io-tag fetch to memory", mem_en, 1);
      if (k == 7) chk("io-tag fetch data", if_rdata, 32'hCAFEF00D);
      step();
    end
    if_req = 0;

    // Reset in the response cycle aborts; the held request completes afterwards.
    d_req = 1; d_we = 0; d_addr = 32'h2004;
    at_neg(); chk("rst-test grant", mem_en, 1);
    step(); RESET = 1'b1;
    at_neg(); chk("aborted d_valid", d_valid, 0); chk("aborted mem_en", mem_en, 0);
    step(); RESET = 1'b0;
    at_neg(); chk("reissue grant", mem_en, 1);
    step(); at_neg(); chk("reissue d_valid", d_valid, 1); chk("reissue d_rdata", d_rdata, 32'h0000BEEF);
    step(); d_req = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
